// File: rtl/serial_mmio_fifo_pkg.sv
// Shared constants for the memory-mapped serial port: default bus addresses,
// status register bit positions and the transmit sequencer state encoding.
package serial_mmio_fifo_pkg;

  localparam logic [31:0] DEFAULT_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] DEFAULT_STAT_ADDR = 32'hBFD0_03FC;

  localparam int STAT_TX_NOT_FULL  = 0;
  localparam int STAT_RX_NOT_EMPTY = 1;
  localparam int STAT_RX_OVERRUN   = 2;
  localparam int STAT_TX_IDLE      = 3;
  localparam int STAT_TX_DROP      = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_e;

  // Edges spent in WAIT_BUSY without busy before assuming the start was lost.
  localparam logic [1:0] LOST_START_LIMIT = 2'd2;

endpackage

// File: rtl/serial_mmio_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted when a
// pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_mmio_fifo.sv
// Memory-mapped serial port: decodes data/status addresses, buffers RX and TX
// bytes in FIFOs and sequences the UART receiver and transmitter handshakes.
module serial_mmio_fifo
  import serial_mmio_fifo_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR = DEFAULT_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR = DEFAULT_STAT_ADDR,
  parameter int          RX_AW     = 4,
  parameter int          TX_AW     = 4
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        bus_ce_i,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_data_i,
  output logic [31:0] bus_data_o,
  output logic        bus_hit_o,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_clear_o,
  input  logic        tx_busy_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  output logic        irq_o
);

  logic           data_sel, stat_sel, bus_rd, bus_wr;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_head;
  logic [RX_AW:0] rx_count;
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [TX_AW:0] tx_count;

  logic       rx_clear_q, rx_clear_d;
  logic       overrun_q, overrun_d;
  logic       drop_q, drop_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  tx_state_e  state_q, state_d;

  // Only bits 7:0 (data) and the W1C bits are meaningful on writes.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bus_data_i[31:8];

  assign data_sel  = (bus_addr_i == DATA_ADDR);
  assign stat_sel  = (bus_addr_i == STAT_ADDR);
  assign bus_hit_o = data_sel || stat_sel;
  assign bus_rd    = bus_ce_i && bus_we_i;
  assign bus_wr    = bus_ce_i && !bus_we_i;

  // Guard on the registered clear: ready is still high on the edge after clear.
  assign rx_push = rx_ready_i && !rx_clear_q;
  assign rx_pop  = bus_rd && data_sel;
  assign tx_push = bus_wr && data_sel;

  sync_fifo #(.WIDTH(8), .AW(RX_AW)) u_rx_fifo (
    .clk_i(clk_50M), .rst_i(rst), .push_i(rx_push), .pop_i(rx_pop),
    .data_i(rx_data_i), .head_o(rx_head), .full_o(rx_full),
    .empty_o(rx_empty), .count_o(rx_count)
  );

  sync_fifo #(.WIDTH(8), .AW(TX_AW)) u_tx_fifo (
    .clk_i(clk_50M), .rst_i(rst), .push_i(tx_push), .pop_i(tx_pop),
    .data_i(bus_data_i[7:0]), .head_o(tx_head), .full_o(tx_full),
    .empty_o(tx_empty), .count_o(tx_count)
  );

  always_comb begin
    rx_clear_d = rx_push;
    overrun_d  = overrun_q;
    drop_d     = drop_q;
    if (bus_wr && stat_sel) begin
      if (bus_data_i[STAT_RX_OVERRUN]) overrun_d = 1'b0;
      if (bus_data_i[STAT_TX_DROP])    drop_d    = 1'b0;
    end
    // Setting after clearing lets a fresh event win over a same-cycle W1C.
    if (rx_push && rx_full && !rx_pop)  overrun_d = 1'b1;
    if (tx_push && tx_full && !tx_pop)  drop_d    = 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rx_clear_q <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wait_cnt_q <= '0;
      state_q    <= TX_IDLE;
    end else begin
      rx_clear_q <= rx_clear_d;
      overrun_q  <= overrun_d;
      drop_q     <= drop_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      wait_cnt_q <= wait_cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:      if (!tx_empty && !tx_busy_i) state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (tx_busy_i)                           state_d = TX_WAIT_DONE;
        else if (wait_cnt_q == LOST_START_LIMIT) state_d = TX_IDLE;
      end
      TX_WAIT_DONE: if (!tx_busy_i) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop     = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    wait_cnt_d = '0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy_i) begin
          tx_pop     = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = tx_head;
        end
      end
      TX_WAIT_BUSY: wait_cnt_d = wait_cnt_q + 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    bus_data_o = '0;
    if (data_sel) begin
      if (!rx_empty) bus_data_o[7:0] = rx_head;
    end else if (stat_sel) begin
      bus_data_o[STAT_TX_NOT_FULL]  = !tx_full;
      bus_data_o[STAT_RX_NOT_EMPTY] = !rx_empty;
      bus_data_o[STAT_RX_OVERRUN]   = overrun_q;
      bus_data_o[STAT_TX_IDLE]      = tx_empty && (state_q == TX_IDLE);
      bus_data_o[STAT_TX_DROP]      = drop_q;
      bus_data_o[15:8]              = 8'(rx_count);
      bus_data_o[23:16]             = 8'(tx_count);
    end
  end

  assign rx_clear_o = rx_clear_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign irq_o      = !rx_empty || overrun_q;

endmodule

// File: doc/serial_mmio_fifo.md
Name: serial_mmio_fifo

Overview:
Memory-mapped serial port controller on the CPU data-bus path, beside the ExtRAM address mapping.
- Decodes the serial data and status addresses.
- Buffers received and transmitted bytes in parametrised FIFOs.
- Sequences the existing async_receiver and async_transmitter through their ready/clear and start/busy handshakes.
- CPU software no longer loses bytes when it polls slowly or issues back-to-back writes.

Parameters:
DATA_ADDR, 32'hBFD003F8, serial data register address
STAT_ADDR, 32'hBFD003FC, serial status register address
RX_AW, 4, log2 RX FIFO depth (16 entries)
TX_AW, 4, log2 TX FIFO depth (16 entries)

Ports:
clk_50M  in  1  system clock
rst  in  1  reset, synchronous, active-high
bus_ce_i  in  1  single-cycle access strobe; one strobe = one access
bus_addr_i  in  32  byte address
bus_we_i  in  1  write enable, active low (0 = write, 1 = read)
bus_data_i  in  32  write data; only [7:0] used
bus_data_o  out  32  read data, combinational from bus_addr_i and current state
bus_hit_o  out  1  bus_addr_i equals DATA_ADDR or STAT_ADDR (combinational, ce-independent)
rx_ready_i  in  1  from async_receiver RxD_data_ready
rx_data_i  in  8  from async_receiver RxD_data
rx_clear_o  out  1  to async_receiver RxD_clear
tx_busy_i  in  1  from async_transmitter TxD_busy
tx_start_o  out  1  to async_transmitter TxD_start
tx_data_o  out  8  to async_transmitter TxD_data
irq_o  out  1  RX FIFO non-empty OR overrun flag set

Behaviour:
- Reset (rst=1 at posedge):
  - Both FIFOs emptied; sticky flags cleared; TX FSM to IDLE.
  - rx_clear_o=0, tx_start_o=0, tx_data_o=0.
  - irq_o=0 after the reset edge. Reset mid-transfer discards all buffered bytes.
- Read of DATA_ADDR:
  - bus_data_o={24'h0, RX head}. Pop on the strobe edge.
  - RX empty: returns 0, no pop.
- Read of STAT_ADDR returns:
  - [0] TX not full
  - [1] RX not empty
  - [2] RX overrun
  - [3] TX FIFO empty and FSM IDLE
  - [4] TX drop
  - [15:8] RX count, zero-extended
  - [23:16] TX count, zero-extended
  - others 0
  - bits [1:0] match the legacy status layout.
- Non-hit address: bus_data_o=0.
- Write to DATA_ADDR:
  - Pushes bus_data_i[7:0] into TX FIFO.
  - TX full: byte dropped, TX drop set.
- Write to STAT_ADDR: W1C on bits 2 and 4; other bits ignored.
- RX intake:
  - Fires when rx_ready_i=1 and rx_clear_o was 0 in the previous cycle. The one-cycle guard exists because ready falls one edge after clear.
  - On each intake: push rx_data_i and pulse rx_clear_o for exactly 1 cycle.
  - RX full with no pop this cycle: byte dropped, overrun set, clear still pulsed.
- FIFO rules:
  - Simultaneous push+pop is legal; count unchanged.
  - Push into a full FIFO is accepted when a pop occurs the same cycle.
  - Pointers wrap modulo 2^AW. Count is AW+1 bits, range 0..2^AW.
- TX FSM:
  - IDLE: if TX not empty and tx_busy_i=0, then tx_data_o<=head, pop, tx_start_o=1 for 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy_i=1, go to WAIT_DONE. After 3 cycles without busy, go to IDLE (lost-start guard).
  - WAIT_DONE: when tx_busy_i=0, go to IDLE.
  - Minimum spacing between tx_start_o pulses: 3 cycles.
- Same-cycle events are independent and all take effect:
  - CPU pop and RX intake on the RX FIFO.
  - CPU push and FSM pop on the TX FIFO.
  - A W1C write and a new overrun in the same cycle: set wins.
- bus_ce_i=0: no state change from the bus side.

Decomposition:
- Shared header serial_defs.vh holds:
  - default DATA/STAT addresses
  - status bit indices
  - TX FSM state encodings (2-bit: IDLE, WAIT_BUSY, WAIT_DONE)
- Sub-module sync_fifo (parameters WIDTH, AW; push/pop/full/empty/count, show-ahead head), instantiated twice: RX with WIDTH=8, AW=RX_AW; TX with WIDTH=8, AW=TX_AW.

Test Plan:
- Reset, then read STAT_ADDR -> 32'h0000_0009 (TX not full, TX idle); irq_o=0.
- Write 8'h41, 8'h42, 8'h43 back-to-back with a transmitter model busy 10 cycles per byte -> tx_start_o pulses carry 41, 42, 43 in order; STAT[3]=1 after the last busy falls.
- Receiver model delivers 8'h55 then 8'hAA:
  - 2 rx_clear_o pulses, 1 cycle each; STAT [15:8]=2, irq_o=1.
  - Reads of DATA_ADDR return 32'h55, then 32'hAA, then 32'h0; irq_o then 0.
- Deliver 17 bytes with no CPU reads (RX_AW=4):
  - STAT[2]=1 and count=16; the 17th byte is lost.
  - Write 32'h4 to STAT_ADDR -> STAT[2]=0.
- Write 17 bytes while tx_busy_i is held at 1:
  - STAT[4]=1; STAT[23:16]=16 while busy is held (the FSM has not yet started any byte).
  - After busy is released, exactly 16 bytes are transmitted.
- Same cycle: CPU pop of a full RX FIFO plus RX intake -> no overrun, count stays 16. Assert rst mid-WAIT_DONE -> FIFOs empty and tx_start_o=0 on the next cycle.
